// File: rtl/sram_page_allocator.sv
// sram_page_allocator: free-list manager for the shared packet SRAM.
// Free page indices live in a circular FIFO. The FIFO is filled with pages
// 0..num_pages-1 during INIT, hands out the head page on a grant and takes
// returned pages in at the tail. An in-use bitmap rejects double frees and
// frees of pages that were never handed out, so the list cannot overflow.
module sram_page_allocator #(
  parameter int unsigned address_width     = 12,
  parameter int unsigned page_offset_width = 6,
  localparam int unsigned PW               = address_width - page_offset_width,
  localparam int unsigned CW               = PW + 1,
  localparam int unsigned num_pages        = 1 << PW
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready,
  input  logic                     alloc_req,
  output logic                     alloc_gnt,
  output logic [address_width-1:0] alloc_addr,
  input  logic                     free_req,
  input  logic [address_width-1:0] free_addr,
  output logic [CW-1:0]            free_count,
  output logic                     empty,
  output logic                     free_err
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [PW-1:0] LAST_PAGE = PW'(num_pages - 1);

  state_t                 state_q, state_d;
  logic [PW-1:0]          head_q, head_d;
  logic [PW-1:0]          tail_q, tail_d;
  logic [CW-1:0]          count_q, count_d;
  logic [num_pages-1:0]   inuse_q, inuse_d;
  logic                   err_q, err_d;

  // Free-list storage: written only at the tail, read combinationally at the head.
  logic [PW-1:0]          mem_q [num_pages];
  logic                   wr_en;
  logic [PW-1:0]          wr_val;

  logic [PW-1:0]          free_page;
  logic [page_offset_width-1:0] free_off;
  logic                   free_ok;

  assign free_page  = free_addr[address_width-1:page_offset_width];
  assign free_off   = free_addr[page_offset_width-1:0];

  assign ready      = (state_q == RUN);
  assign empty      = (count_q == '0);
  assign free_count = count_q;
  assign free_err   = err_q;
  assign alloc_gnt  = alloc_req & ready & ~empty;
  assign alloc_addr = {mem_q[head_q], {page_offset_width{1'b0}}};

  // A free is only accepted for a page-aligned address of a page currently handed out.
  assign free_ok    = ready & free_req & (free_off == '0) & inuse_q[free_page];

  // Next-state: INIT seeds one page per cycle; RUN serves grants and returns.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    inuse_d = inuse_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_val  = '0;
    case (state_q)
      INIT: begin
        wr_en   = 1'b1;
        wr_val  = tail_q;
        tail_d  = tail_q + 1'b1;
        count_d = count_q + 1'b1;
        err_d   = free_req;
        if (tail_q == LAST_PAGE) state_d = RUN;
      end
      RUN: begin
        if (alloc_gnt) begin
          head_d                 = head_q + 1'b1;
          inuse_d[mem_q[head_q]] = 1'b1;
        end
        // The granted page's in-use bit is still clear here, so freeing it in
        // the same cycle falls into the reject path.
        if (free_ok) begin
          wr_en              = 1'b1;
          wr_val             = free_page;
          tail_d             = tail_q + 1'b1;
          inuse_d[free_page] = 1'b0;
        end
        count_d = count_q + CW'(free_ok) - CW'(alloc_gnt);
        err_d   = free_req & ~free_ok;
      end
      default: state_d = INIT;
    endcase
  end

  // Control registers with synchronous reset back to an empty, uninitialised list.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      inuse_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      inuse_q <= inuse_d;
      err_q   <= err_d;
    end
  end

  // Free-list entries need no reset: INIT rewrites every slot before use.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[tail_q] <= wr_val;
  end

endmodule

// File: tb/tb_sram_page_allocator.sv
// Bench for sram_page_allocator: behavioural free-list model (queue + bitmap),
// a table of single-cycle steps, hand-written corner sequences and random traffic.
module tb_sram_page_allocator;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic        alloc_req;
  logic        alloc_gnt;
  logic [11:0] alloc_addr;
  logic        free_req;
  logic [11:0] free_addr;
  logic [6:0]  free_count;
  logic        empty;
  logic        free_err;

  sram_page_allocator dut (
    .clk(clk), .rst(rst), .ready(ready),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_addr(alloc_addr),
    .free_req(free_req), .free_addr(free_addr),
    .free_count(free_count), .empty(empty), .free_err(free_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of free pages, in-use flags, remaining init cycles.
  int q_free[$];
  bit used[64];
  int init_left;
  bit m_err;

  // Values seen on the DUT during the last cycle() call.
  bit       s_gnt;
  int       s_addr;
  int       s_count;
  bit       s_err;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; alloc_req = 1'b1; free_req = 1'b0; free_addr = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    q_free.delete();
    foreach (used[i]) used[i] = 1'b0;
    init_left = 64;
    m_err = 1'b0;
    chk("rst_ready", ready, 0);
    chk("rst_count", free_count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_err", free_err, 0);
    chk("rst_gnt", alloc_gnt, 0);
    alloc_req = 1'b0;
  endtask

  // One clock: drive, check combinational outputs, clock, update model, check state.
  task automatic cycle(input bit a, input bit f, input logic [11:0] fa);
    bit rdy, nonempty, acc;
    int idx, p;
    alloc_req = a; free_req = f; free_addr = fa;
    #2;
    rdy      = (init_left == 0);
    nonempty = (q_free.size() > 0);
    s_gnt  = alloc_gnt;
    s_addr = alloc_addr;
    chk("gnt", alloc_gnt, int'(a && rdy && nonempty));
    if (nonempty) chk("alloc_addr", alloc_addr, q_free[0] * 64);
    @(posedge clk);
    if (!rdy) begin
      q_free.push_back(64 - init_left);
      init_left--;
      m_err = f;
    end else begin
      idx = int'(fa[11:6]);
      acc = f && (fa[5:0] == 6'd0) && used[idx];
      if (a && nonempty) begin
        p = q_free.pop_front();
        used[p] = 1'b1;
      end
      if (acc) begin
        used[idx] = 1'b0;
        q_free.push_back(idx);
      end
      m_err = f && !acc;
    end
    #1;
    s_count = free_count;
    s_err   = free_err;
    chk("ready", ready, int'(init_left == 0));
    chk("free_count", free_count, q_free.size());
    chk("empty", empty, int'(q_free.size() == 0));
    chk("free_err", free_err, int'(m_err));
    alloc_req = 1'b0; free_req = 1'b0;
  endtask

  // Idle until ready, bounded; returns cycles spent with ready low.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 200) begin
      cycle(1'b0, 1'b0, 12'h000);
      n++;
    end
  endtask

  typedef struct {
    bit          a;
    bit          f;
    logic [11:0] fa;
    bit          gnt;
    int          addr;
    int          cnt;
    bit          err;
  } step_t;

  step_t tbl[10];

  initial begin
    int n;
    logic [11:0] fa;
    rst = 1'b0; alloc_req = 1'b0; free_req = 1'b0; free_addr = '0;
    @(posedge clk); #1;

    tbl[0] = '{1, 0, 12'h000, 1, 12'h000, 63, 0};
    tbl[1] = '{1, 0, 12'h000, 1, 12'h040, 62, 0};
    tbl[2] = '{1, 0, 12'h000, 1, 12'h080, 61, 0};
    tbl[3] = '{0, 1, 12'h040, 0, 12'h0C0, 62, 0};
    tbl[4] = '{0, 1, 12'h040, 0, 12'h0C0, 62, 1};
    tbl[5] = '{0, 1, 12'h041, 0, 12'h0C0, 62, 1};
    tbl[6] = '{0, 0, 12'h000, 0, 12'h0C0, 62, 0};
    tbl[7] = '{1, 1, 12'h000, 1, 12'h0C0, 62, 0};
    tbl[8] = '{1, 1, 12'h100, 1, 12'h100, 61, 1};
    tbl[9] = '{0, 1, 12'h080, 0, 12'h140, 62, 0};

    // Init length and post-init state
    do_reset();
    wait_ready(n);
    chk("init_cycles", n, 64);
    chk("init_count", free_count, 64);
    chk("init_empty", empty, 0);
    chk("init_addr", alloc_addr, 12'h000);

    // Table-driven single-cycle steps from a fresh list
    foreach (tbl[i]) begin
      cycle(tbl[i].a, tbl[i].f, tbl[i].fa);
      chk($sformatf("tbl%0d_gnt", i), s_gnt, tbl[i].gnt);
      chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_cnt", i), s_count, tbl[i].cnt);
      chk($sformatf("tbl%0d_err", i), s_err, tbl[i].err);
    end

    // Free during INIT is rejected
    do_reset();
    cycle(1'b0, 1'b1, 12'h000);
    chk("init_free_err", s_err, 1);
    chk("init_free_cnt", s_count, 1);
    wait_ready(n);

    // Drain and refill
    do_reset();
    wait_ready(n);
    for (int i = 0; i < 64; i++) cycle(1'b1, 1'b0, 12'h000);
    chk("drain_empty", empty, 1);
    cycle(1'b1, 1'b0, 12'h000);
    chk("drain_gnt", s_gnt, 0);
    cycle(1'b0, 1'b1, 12'h140);
    chk("refill_empty", empty, 0);
    chk("refill_addr", alloc_addr, 12'h140);

    // Simultaneous grant and free
    do_reset();
    wait_ready(n);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 12'h000);
    cycle(1'b1, 1'b1, 12'h000);
    chk("sim_gnt", s_gnt, 1);
    chk("sim_addr", s_addr, 12'h280);
    chk("sim_cnt", s_count, 54);
    chk("sim_err", s_err, 0);
    for (int i = 0; i < 53; i++) cycle(1'b1, 1'b0, 12'h000);
    chk("sim_reissue", alloc_addr, 12'h000);
    chk("sim_last_cnt", free_count, 1);

    // Reset mid-operation
    do_reset();
    wait_ready(n);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 12'h000);
    do_reset();
    wait_ready(n);
    chk("mid_init_cycles", n, 64);
    chk("mid_count", free_count, 64);
    cycle(1'b1, 1'b0, 12'h000);
    chk("mid_first_addr", s_addr, 12'h000);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        int inuse_list[$];
        foreach (used[j]) if (used[j]) inuse_list.push_back(j);
        if (inuse_list.size() > 0 && $urandom_range(0, 3) != 0)
          fa = 12'(inuse_list[$urandom_range(0, inuse_list.size() - 1)] * 64);
        else
          fa = 12'($urandom_range(0, 4095));
        cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 4), fa);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
